regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (we/rd/write_data) between the
//  ALU writeback path and the load/store-unit (LSU) writeback path.
//  Holds a per-register pending scoreboard and stalls issue on RAW/WAW hazards.
//  Sits between the execute/memory stages and the 32x32 register file.
// PARAMETERS
//  XLEN         32  data width of write data
//  NREG         32  architectural registers; index width is $clog2(NREG) = 5
//  STARVE_LIMIT 3   consecutive ALU denials before ALU is forced to win
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  alu_valid  in   1     ALU result available
//  alu_rd     in   5     ALU destination register
//  alu_data   in   XLEN  ALU result
//  alu_ready  out  1     ALU result accepted this cycle
//  lsu_valid  in   1     load data available
//  lsu_rd     in   5     load destination register
//  lsu_data   in   XLEN  load data
//  lsu_ready  out  1     load data accepted this cycle
//  iss_valid  in   1     instruction presented for issue
//  iss_rd     in   5     its destination (5'd0 = no write)
//  iss_rs1    in   5     its source 1
//  iss_rs2    in   5     its source 2
//  iss_stall  out  1     issue must hold; combinational
//  rf_we      out  1     to register-file we; registered
//  rf_rd      out  5     to register-file rd; registered
//  rf_wdata   out  XLEN  to register-file write_data; registered
// BEHAVIOUR
//  Reset: rf_we=0, rf_rd=0, rf_wdata=0, scoreboard all 0, starve counter 0.
//  Reset mid-operation drops any write in flight. No write may reach the
//  register file while rst_n=0.
//  Handshake: a transfer happens when valid&&ready in the same cycle. ready is
//  combinational from valid and arbiter state. A source may hold valid
//  indefinitely, with stable rd/data, until it is accepted.
//  Arbitration, one grant per cycle:
//   - Only one source valid: that source is granted.
//   - Both sources valid: LSU wins unless starve_cnt==STARVE_LIMIT, in which
//     case ALU wins.
//   - starve_cnt increments when the ALU is valid and denied. It clears to 0
//     on an ALU grant, or when alu_valid=0. It saturates at STARVE_LIMIT.
//  Latency: granted rd/data appear on rf_* at the next clock edge. rf_we=1 for
//  exactly one cycle. The register file writes at the following edge.
//  Writes to rd==0: accepted (ready=1) but rf_we stays 0.
//  Scoreboard pending[1..31]; pending[0] is constant 0.
//   - Set: the edge where iss_valid && !iss_stall && iss_rd!=0 sets
//     pending[iss_rd].
//   - Clear: the edge where rf_we=1 clears pending[rf_rd]. The register file
//     has written on that same edge, so the next-cycle read returns new data.
//   - Set and clear of the same index on the same edge: set wins.
//  iss_stall = iss_valid && (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd]).
//   - Covers RAW on both sources and WAW on the destination. x0 never stalls.
//  No bypass: data written this cycle is not forwarded to issue.
// STRUCTURE
//  Shared package/include: REG_IDX_W=5, REG_ZERO=5'd0, and the source-select
//  encoding SRC_ALU=1'b0 / SRC_LSU=1'b1.
//  Sub-module wb_scoreboard owns pending[] set/clear and the stall compare.
//  Arbiter, starve counter and output register stay in the top module.
// TESTING
//  1. Reset: rst_n=0 -> rf_we=0, iss_stall=0 for any inputs. Release; issue
//     rd=5 -> pending[5]=1.
//  2. ALU only: alu_valid, rd=3, data=32'hDEADBEEF -> alu_ready=1 the same
//     cycle; next cycle rf_we=1, rf_rd=3, rf_wdata=32'hDEADBEEF.
//  3. Contention: both valid, held for 5 cycles -> LSU granted on cycles 0-2,
//     ALU granted on cycle 3 (STARVE_LIMIT=3), LSU granted on cycle 4.
//  4. RAW: issue rd=7, then issue rs1=7 -> iss_stall=1 until the cycle after
//     rf_we with rf_rd=7, then 0.
//  5. Simultaneous events: rf_we with rf_rd=9 on the same edge as issue of
//     rd=9 -> pending[9] stays 1. An ALU write with rd=0 -> alu_ready=1 and
//     rf_we=0.
//  6. Mid-operation reset: rst_n low while alu_valid is high and pending is
//     nonzero -> all pending cleared, rf_we=0, no write on release.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// register index width, the x0 index and the writeback source-select encoding.
package regfile_wb_arbiter_pkg;

  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared on register-file write,
// plus the RAW/WAW stall compare presented back to issue.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_iss_valid,
  input  logic [REG_IDX_W-1:0] i_iss_rd,
  input  logic [REG_IDX_W-1:0] i_iss_rs1,
  input  logic [REG_IDX_W-1:0] i_iss_rs2,
  input  logic                 i_wb_we,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  output logic                 o_iss_stall
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;
  logic            w_set;

  assign o_iss_stall = i_iss_valid &&
                       (r_pending[i_iss_rs1] | r_pending[i_iss_rs2] | r_pending[i_iss_rd]);

  assign w_set = i_iss_valid && !o_iss_stall && (i_iss_rd != REG_ZERO);

  // Clear applied before set so a same-index collision leaves the entry pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_wb_we) w_pending_nxt[i_wb_rd] = 1'b0;
    if (w_set)   w_pending_nxt[i_iss_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and LSU writeback,
// with ALU anti-starvation, a registered write stage and a hazard scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 lsu_valid,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 lsu_ready,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  output logic                 iss_stall,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]      rf_wdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]     r_starve_cnt;
  logic                 w_starved;
  logic                 w_grant;
  logic                 w_sel;
  logic [REG_IDX_W-1:0] w_sel_rd;
  logic [XLEN-1:0]      w_sel_data;
  logic                 r_we;
  logic [REG_IDX_W-1:0] r_rd;
  logic [XLEN-1:0]      r_wdata;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_grant   = alu_valid || lsu_valid;

  // LSU has priority unless the ALU has been denied STARVE_LIMIT times in a row.
  always_comb begin
    w_sel = SRC_LSU;
    if (alu_valid && (!lsu_valid || w_starved)) w_sel = SRC_ALU;
  end

  assign alu_ready  = w_grant && (w_sel == SRC_ALU);
  assign lsu_ready  = w_grant && (w_sel == SRC_LSU);
  assign w_sel_rd   = (w_sel == SRC_ALU) ? alu_rd   : lsu_rd;
  assign w_sel_data = (w_sel == SRC_ALU) ? alu_data : lsu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!alu_valid || alu_ready) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Write stage: x0 writes are accepted upstream but never strobe the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_rd    <= REG_ZERO;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant && (w_sel_rd != REG_ZERO);
      if (w_grant) begin
        r_rd    <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_rd    = r_rd;
  assign rf_wdata = r_wdata;

  wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .i_iss_rs1   (iss_rs1),
    .i_iss_rs2   (iss_rs2),
    .i_wb_we     (r_we),
    .i_wb_rd     (r_rd),
    .o_iss_stall (iss_stall)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: table-driven arbitration vectors
// with a write scoreboard, plus sequences for reset, hazards and edge collisions.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, iss_valid;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, iss_rs1, iss_rs2;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, iss_stall, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        exp_ar;
    logic        exp_lr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0;
    iss_valid = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
  endtask

  task automatic probe(input string name, input logic [4:0] rs1, input logic exp);
    iss_valid = 1'b1; iss_rd = 5'd0; iss_rs1 = rs1; iss_rs2 = 5'd0;
    #1;
    chk(name, iss_stall, exp);
    iss_valid = 1'b0; iss_rs1 = 5'd0;
  endtask

  task automatic check_rf(input int idx);
    wr_t w;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk($sformatf("vec%0d rf_we", idx), rf_we, 1'b1);
      chk($sformatf("vec%0d rf_rd", idx), rf_rd, w.rd);
      chk($sformatf("vec%0d rf_wdata", idx), rf_wdata, w.data);
    end else begin
      chk($sformatf("vec%0d rf_we idle", idx), rf_we, 1'b0);
    end
  endtask

  initial begin
    // av ard ad             lv lrd ld             ar lr
    vecs[0]  = '{1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0};
    vecs[1]  = '{0, 5'd0,  32'h0,        1, 5'd4,  32'h12345678, 0, 1};
    vecs[2]  = '{1, 5'd10, 32'hA0A0A0A0, 1, 5'd11, 32'h11110000, 0, 1};
    vecs[3]  = '{1, 5'd10, 32'hA0A0A0A0, 1, 5'd11, 32'h11110001, 0, 1};
    vecs[4]  = '{1, 5'd10, 32'hA0A0A0A0, 1, 5'd11, 32'h11110002, 0, 1};
    vecs[5]  = '{1, 5'd10, 32'hA0A0A0A0, 1, 5'd11, 32'h11110003, 1, 0};
    vecs[6]  = '{1, 5'd14, 32'hB0B0B0B0, 1, 5'd11, 32'h11110004, 0, 1};
    vecs[7]  = '{1, 5'd0,  32'h0000CAFE, 0, 5'd0,  32'h0,        1, 0};
    vecs[8]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0};
    vecs[9]  = '{1, 5'd12, 32'hC0C0C0C0, 1, 5'd13, 32'h22220000, 0, 1};
    vecs[10] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0};
    vecs[11] = '{1, 5'd12, 32'hC0C0C0C0, 1, 5'd13, 32'h22220001, 0, 1};
    vecs[12] = '{1, 5'd12, 32'hC0C0C0C0, 1, 5'd13, 32'h22220002, 0, 1};
    vecs[13] = '{1, 5'd12, 32'hC0C0C0C0, 1, 5'd13, 32'h22220003, 0, 1};
    vecs[14] = '{1, 5'd12, 32'hC0C0C0C0, 1, 5'd13, 32'h22220004, 1, 0};
    vecs[15] = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h33333333, 0, 1};

    // Reset held with every input active: nothing may reach the register file.
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55555555;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h66666666;
    iss_valid = 1'b1; iss_rd = 5'd9; iss_rs1 = 5'd5; iss_rs2 = 5'd7;
    tick;
    tick;
    chk("rst rf_we", rf_we, 1'b0);
    chk("rst rf_rd", rf_rd, 5'd0);
    chk("rst rf_wdata", rf_wdata, 32'h0);
    chk("rst iss_stall", iss_stall, 1'b0);
    idle;
    rst_n = 1'b1;
    tick;
    chk("post-rst rf_we", rf_we, 1'b0);

    iss_valid = 1'b1; iss_rd = 5'd5;
    #1;
    chk("issue rd5 no stall", iss_stall, 1'b0);
    tick;
    iss_valid = 1'b0; iss_rd = 5'd0;
    probe("pending5 rs1", 5'd5, 1'b1);
    iss_valid = 1'b1; iss_rs2 = 5'd5;
    #1;
    chk("pending5 rs2", iss_stall, 1'b1);
    iss_valid = 1'b0;
    #1;
    chk("stall gated by iss_valid", iss_stall, 1'b0);
    iss_rs2 = 5'd0;

    // Arbitration table; expected writes queued as each vector is driven.
    for (int i = 0; i < 16; i++) begin
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
      #1;
      chk($sformatf("vec%0d alu_ready", i), alu_ready, vecs[i].exp_ar);
      chk($sformatf("vec%0d lsu_ready", i), lsu_ready, vecs[i].exp_lr);
      if (vecs[i].exp_ar && vecs[i].ard != 5'd0) exp_q.push_back('{vecs[i].ard, vecs[i].ad});
      else if (vecs[i].exp_lr && vecs[i].lrd != 5'd0) exp_q.push_back('{vecs[i].lrd, vecs[i].ld});
      tick;
      check_rf(i);
    end
    idle;
    tick;
    chk("queue drained", exp_q.size(), 0);

    // RAW on rd 7 held until the cycle after the write strobe.
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    chk("raw issue rd7", iss_stall, 1'b0);
    tick;
    iss_rd = 5'd0; iss_rs1 = 5'd7;
    #1;
    chk("raw stall c0", iss_stall, 1'b1);
    tick;
    chk("raw stall c1", iss_stall, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77777777;
    #1;
    chk("raw alu_ready", alu_ready, 1'b1);
    tick;
    alu_valid = 1'b0;
    #1;
    chk("raw rf_we", rf_we, 1'b1);
    chk("raw rf_rd", rf_rd, 5'd7);
    chk("raw stall during write", iss_stall, 1'b1);
    tick;
    chk("raw stall released", iss_stall, 1'b0);
    chk("raw rf_we one cycle", rf_we, 1'b0);
    idle;

    // Issue of rd 9 on the same edge that writes rd 9: entry must stay pending.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99999999;
    tick;
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    chk("sim rf_we", rf_we, 1'b1);
    chk("sim rf_rd", rf_rd, 5'd9);
    chk("sim issue no stall", iss_stall, 1'b0);
    tick;
    iss_valid = 1'b0; iss_rd = 5'd0;
    probe("sim pending9 kept", 5'd9, 1'b1);
    tick;
    probe("sim pending9 later", 5'd9, 1'b1);

    // Reset while a write is in flight and the ALU keeps requesting.
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick;
    iss_valid = 1'b0; iss_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'h13131313;
    tick;
    chk("mid in-flight rf_we", rf_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid async rf_we", rf_we, 1'b0);
    probe("mid pending12 cleared", 5'd12, 1'b0);
    tick;
    chk("mid held rf_we", rf_we, 1'b0);
    alu_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick;
    chk("mid release rf_we", rf_we, 1'b0);
    probe("mid pending9 cleared", 5'd9, 1'b0);
    probe("mid pending5 cleared", 5'd5, 1'b0);
    tick;
    chk("mid no late write", rf_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
